// File: rtl/btn_capture_reg_if.sv
// Button/data/status bundle between board-side stimulus and the capture register.
// The master drives buttons and data; the slave (btn_capture_reg) drives the outputs.
interface btn_capture_reg_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn;
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   q;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic               led_and;
    logic               led_or;
    logic [7:0]         load_count;

    modport master (
        output btn,
        output data,
        input  q,
        input  btn_level,
        input  btn_rise,
        input  led_and,
        input  led_or,
        input  load_count
    );

    modport slave (
        input  btn,
        input  data,
        output q,
        output btn_level,
        output btn_rise,
        output led_and,
        output led_or,
        output load_count
    );
endinterface

// File: rtl/btn_capture_reg.sv
// Debounced push-button front end: clean levels, rise pulses, and a word register
// loaded by button 0 and cleared by button 1, with an 8-bit load counter.
module btn_capture_reg #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic              clk,
    input logic              reset,
    btn_capture_reg_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] rise_q;
    logic [NUM_BTN-1:0] rise_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   q_d;
    logic [7:0]         load_count_q;
    logic [7:0]         load_count_d;

    // Per-channel debounce: accept a new level after DEBOUNCE_CYCLES disagreeing samples in a row.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic differ;
        logic at_max;

        assign differ     = s2_q[g] ^ level_q[g];
        assign at_max     = (cnt_q[g] == CNT_MAX);
        assign cnt_d[g]   = (!differ || at_max) ? '0 : cnt_q[g] + CNT_W'(1);
        assign level_d[g] = (differ && at_max) ? s2_q[g] : level_q[g];
        assign rise_d[g]  = differ && at_max && s2_q[g];
    end

    // Capture decision; a simultaneous clear beats a load.
    always_comb begin
        q_d          = q_q;
        load_count_d = load_count_q;
        if (rise_d[1]) begin
            q_d = '0;
        end else if (rise_d[0]) begin
            q_d          = bus.data;
            load_count_d = load_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            cnt_q        <= '{default: '0};
            q_q          <= '0;
            load_count_q <= '0;
        end else begin
            s1_q         <= bus.btn;
            s2_q         <= s1_q;
            level_q      <= level_d;
            rise_q       <= rise_d;
            cnt_q        <= cnt_d;
            q_q          <= q_d;
            load_count_q <= load_count_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.btn_level  = level_q;
    assign bus.btn_rise   = rise_q;
    assign bus.load_count = load_count_q;
    assign bus.led_and    = level_q[0] & level_q[1];
    assign bus.led_or     = level_q[0] | level_q[1];
endmodule

// File: tb/tb_btn_capture_reg.sv
// Bench for btn_capture_reg: directed scenarios plus random button activity,
// all checked every cycle against a sample-window reference model.
module tb_btn_capture_reg;
    localparam int unsigned W  = 32;
    localparam int unsigned NB = 3;
    localparam int unsigned D  = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rise_cnt0 = 0;

    btn_capture_reg_if #(.WIDTH(W), .NUM_BTN(NB)) bif ();

    btn_capture_reg #(.WIDTH(W), .NUM_BTN(NB), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synced value is the raw button two edges back; a channel
    // flips once its last D synced samples all disagree with the current level.
    logic [NB-1:0] m_s1, m_s2, m_level, m_rise;
    logic [W-1:0]  m_q;
    logic [7:0]    m_lc;
    bit            m_hist [NB][$];
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        logic [NB-1:0] s2_now;
        bit all_differ;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_q = '0; m_lc = '0;
            for (int c = 0; c < int'(NB); c++) m_hist[c].delete();
            m_valid = 1'b1;
        end else begin
            s2_now = m_s2;
            m_s2   = m_s1;
            m_s1   = bif.btn;
            m_rise = '0;
            for (int c = 0; c < int'(NB); c++) begin
                m_hist[c].push_back(s2_now[c]);
                if (m_hist[c].size() > int'(D)) void'(m_hist[c].pop_front());
                all_differ = (m_hist[c].size() == int'(D));
                for (int k = 0; k < m_hist[c].size(); k++)
                    if (m_hist[c][k] == m_level[c]) all_differ = 1'b0;
                if (all_differ) begin
                    m_rise[c]  = !m_level[c];
                    m_level[c] = !m_level[c];
                end
            end
            if (m_rise[1]) m_q = '0;
            else if (m_rise[0]) begin
                m_q  = bif.data;
                m_lc = m_lc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (bif.btn_rise[0] === 1'b1) rise_cnt0++;
        if (m_valid) begin
            chk("model_q", 64'(bif.q), 64'(m_q));
            chk("model_level", 64'(bif.btn_level), 64'(m_level));
            chk("model_rise", 64'(bif.btn_rise), 64'(m_rise));
            chk("model_load_count", 64'(bif.load_count), 64'(m_lc));
            chk("model_led_and", 64'(bif.led_and), 64'(m_level[0] & m_level[1]));
            chk("model_led_or", 64'(bif.led_or), 64'(m_level[0] | m_level[1]));
        end
    end

    // Counts rising edges until btn_rise[ch] is seen (just after the edge); -1 on timeout.
    task automatic wait_rise(input int ch, input int max_edges, output int edge_no);
        edge_no = -1;
        for (int e = 1; e <= max_edges; e++) begin
            @(posedge clk);
            #1;
            if (bif.btn_rise[ch] === 1'b1) begin
                edge_no = e;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic release_all();
        @(negedge clk);
        bif.btn = '0;
        repeat (D + 6) @(negedge clk);
    endtask

    initial begin
        int e;
        int rc_before;
        logic [W-1:0] last_data;
        int timer [NB];

        reset    = 1'b0;
        bif.btn  = '0;
        bif.data = '0;
        repeat (3) @(negedge clk);
        chk("reset_q", 64'(bif.q), 64'd0);
        chk("reset_level", 64'(bif.btn_level), 64'd0);
        chk("reset_load_count", 64'(bif.load_count), 64'd0);
        reset = 1'b1;

        // Clean press of load
        @(negedge clk);
        bif.data   = 32'hDEADBEEF;
        bif.btn[0] = 1'b1;
        wait_rise(0, 40, e);
        chk("t1_rise_edge", 64'(e), 64'd18);
        chk("t1_q", 64'(bif.q), 64'hDEADBEEF);
        chk("t1_load_count", 64'(bif.load_count), 64'd1);
        @(posedge clk); #1;
        chk("t1_pulse_width", 64'(bif.btn_rise[0]), 64'd0);
        release_all();

        // Bouncing load button, then a steady hold
        rc_before = rise_cnt0;
        for (int k = 0; k < 19; k++) begin
            bif.btn[0] = (k % 2 == 1);
            repeat (5) @(negedge clk);
        end
        bif.btn[0] = 1'b1;
        wait_rise(0, 40, e);
        chk("t2_rise_edge", 64'(e), 64'd18);
        repeat (5) @(negedge clk);
        chk("t2_single_pulse", 64'(rise_cnt0 - rc_before), 64'd1);
        release_all();

        // Load then clear
        do_reset();
        @(negedge clk);
        bif.data   = 32'h12345678;
        bif.btn[0] = 1'b1;
        repeat (D + 6) @(negedge clk);
        chk("t3_q_loaded", 64'(bif.q), 64'h12345678);
        release_all();
        bif.btn[1] = 1'b1;
        wait_rise(1, 40, e);
        chk("t3_clear_edge", 64'(e), 64'd18);
        chk("t3_q_cleared", 64'(bif.q), 64'd0);
        chk("t3_load_count", 64'(bif.load_count), 64'd1);
        release_all();

        // Load and clear together: clear wins
        @(negedge clk);
        bif.data = 32'hA5A5A5A5;
        bif.btn  = 3'b011;
        wait_rise(1, 40, e);
        chk("t4_both_edge", 64'(e), 64'd18);
        chk("t4_rise0", 64'(bif.btn_rise[0]), 64'd1);
        chk("t4_q", 64'(bif.q), 64'd0);
        chk("t4_load_count", 64'(bif.load_count), 64'd1);
        chk("t4_led_and", 64'(bif.led_and), 64'd1);
        release_all();

        // 256 loads wrap the counter
        do_reset();
        last_data = '0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            last_data  = $urandom;
            bif.data   = last_data;
            bif.btn[0] = 1'b1;
            repeat (D + 4) @(negedge clk);
            bif.btn[0] = 1'b0;
            repeat (D + 4) @(negedge clk);
        end
        chk("t5_load_count_wrap", 64'(bif.load_count), 64'd0);
        chk("t5_q_last", 64'(bif.q), 64'(last_data));

        // Reset in the middle of a debounce
        @(negedge clk);
        bif.btn[0] = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_reset_q", 64'(bif.q), 64'd0);
            chk("t6_reset_outputs", 64'({bif.btn_level, bif.btn_rise, bif.load_count}), 64'd0);
        end
        reset = 1'b1;
        wait_rise(0, 40, e);
        chk("t6_fresh_edge", 64'(e), 64'd18);
        release_all();

        // Random button activity on all channels with occasional resets
        for (int c = 0; c < int'(NB); c++) timer[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            bif.data = $urandom;
            for (int c = 0; c < int'(NB); c++) begin
                if (timer[c] == 0) begin
                    bif.btn[c] = 1'($urandom_range(0, 1));
                    timer[c]   = int'($urandom_range(1, 40));
                end else begin
                    timer[c]--;
                end
            end
            reset = ($urandom_range(0, 599) != 0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
